cordic_angle_seq: RTL and testbench
===================================

CORDIC_ANGLE_SEQ -- requirements
Module: cordic_angle_seq

Interface
REQ-001 Parameter N_ITER, default 16: number of micro-rotations per operation, legal range 1..16.
REQ-002 Clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Reset  input  1  reset, synchronous and active-high.
REQ-004 Start  input  1  request a new operation; sampled only in IDLE.
REQ-005 Z_sign  input  1  sign of the current Z residual from the downstream Z stage (1 = negative).
REQ-006 Enable  output  1  step strobe to the downstream Z/X/Y stages; high for exactly one cycle per iteration.
REQ-007 Arctan  output  16  signed step angle presented with Enable; Q3.13 radians (8192 = 1.0 rad).
REQ-008 Iter  output  4  index i of the iteration being issued.
REQ-009 Busy  output  1  high from the cycle after Start is accepted through the DONE cycle.
REQ-010 Done  output  1  one-cycle pulse marking completion.

Function
REQ-011 FSM states SHALL be IDLE, ISSUE, WAIT and DONE, with all outputs registered.
REQ-012 IDLE -> ISSUE SHALL occur when Start=1; Start SHALL be ignored in every other state.
REQ-013 ISSUE -> WAIT SHALL occur unconditionally.
REQ-014 WAIT -> ISSUE SHALL occur when Iter < N_ITER-1; otherwise WAIT -> DONE.
REQ-015 DONE -> IDLE SHALL occur unconditionally; Start in the DONE cycle SHALL be ignored.
REQ-016 Iter SHALL load 0 on IDLE->ISSUE and SHALL increment by 1 on each WAIT->ISSUE; there is no wrap, since N_ITER<=16.
REQ-017 Enable SHALL be 1 only in ISSUE and 0 in every other state.
REQ-018 Arctan SHALL load on every transition into ISSUE as follows: +T[i] if Z_sign=1 at that edge, -T[i] if Z_sign=0, where i is the new Iter value.
REQ-019 T[0..15] SHALL be 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0, 0 (round-to-nearest of atan(2^-i)*8192).
REQ-020 Arctan SHALL hold its value in WAIT and DONE, and SHALL be 0 in IDLE.
REQ-021 The WAIT cycle SHALL give the 1-cycle-latency downstream adder time to update the residual, so that Z_sign sampled at WAIT->ISSUE reflects the previous step.
REQ-022 Busy SHALL be 1 in ISSUE, WAIT and DONE, and 0 in IDLE.
REQ-023 Done SHALL be 1 only in DONE.
REQ-024 Latency SHALL be fixed: with Start sampled at edge 0, Done is high in cycle 2*N_ITER+1 and IDLE is reached at edge 2*N_ITER+2.
REQ-025 Negation of T[i] SHALL be exact two's complement; no table value can overflow 16 bits.
REQ-026 Z_sign SHALL be don't-care except at IDLE->ISSUE and WAIT->ISSUE edges.

Reset
REQ-027 Reset=1 at a rising edge SHALL force IDLE with Enable=0, Arctan=0, Iter=0, Busy=0 and Done=0, from any state.
REQ-028 Reset SHALL take priority over Start when both are asserted at the same edge.
REQ-029 A reset mid-operation SHALL abandon the operation with no Done pulse; the first Start after Reset deasserts SHALL begin a fresh operation at Iter=0.

Verification
REQ-030 N_ITER=16, Start for 1 cycle, Z_sign=1 held -> 16 Enable pulses on alternate cycles; Arctan=+6434, +3798, ..., +1, 0, 0; Done in cycle 33; Busy high for cycles 1..33.
REQ-031 Z_sign=0 at start, then toggled each WAIT -> Arctan sequence -6434, +3798, -2007, +1019, ...; Iter follows 0..15.
REQ-032 Start held high continuously -> operations run back to back with exactly one IDLE cycle between the Done pulse and the next ISSUE; no extra Enable pulses occur during Busy.
REQ-033 Reset asserted in the WAIT cycle after Iter=5 -> next cycle shows IDLE with all outputs 0, no Done pulse; the next Start issues Iter=0 with Arctan=±6434.
REQ-034 N_ITER=1 -> a single Enable pulse with Arctan=±6434, Done in cycle 3.
REQ-035 Reset and Start asserted at the same edge -> block stays in IDLE and Enable stays 0.

Source files
------------

// File: rtl/cordic_angle_seq_if.sv
// Handshake bundle between the CORDIC angle sequencer and its user.
// master: requester/downstream stage side; slave: the sequencer itself.
interface cordic_angle_seq_if;
    logic               start_i;
    logic               z_sign_i;
    logic               enable_o;
    logic signed [15:0] arctan_o;
    logic [3:0]         iter_o;
    logic               busy_o;
    logic               done_o;

    modport master (
        output start_i, z_sign_i,
        input  enable_o, arctan_o, iter_o, busy_o, done_o
    );

    modport slave (
        input  start_i, z_sign_i,
        output enable_o, arctan_o, iter_o, busy_o, done_o
    );
endinterface

// File: rtl/cordic_angle_seq.sv
// CORDIC rotation-angle sequencer: issues N_ITER signed atan steps to Z/X/Y stages.
// Ports: clk_i, rst_i (sync, active-high); bus (slave): start/z_sign in, enable/arctan/iter/busy/done out.
module cordic_angle_seq #(
    parameter int N_ITER = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    cordic_angle_seq_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] LAST = 4'(N_ITER - 1);

    logic [1:0]         state_q, state_d;
    logic [3:0]         iter_q, iter_d;
    logic signed [15:0] arctan_q, arctan_d;
    logic               enable_q, busy_q, done_q;

    // atan(2^-i) in Q3.13, round-to-nearest
    function automatic logic signed [15:0] atan_lut(input logic [3:0] i);
        logic signed [15:0] t;
        case (i)
            4'd0:    t = 16'sd6434;
            4'd1:    t = 16'sd3798;
            4'd2:    t = 16'sd2007;
            4'd3:    t = 16'sd1019;
            4'd4:    t = 16'sd511;
            4'd5:    t = 16'sd256;
            4'd6:    t = 16'sd128;
            4'd7:    t = 16'sd64;
            4'd8:    t = 16'sd32;
            4'd9:    t = 16'sd16;
            4'd10:   t = 16'sd8;
            4'd11:   t = 16'sd4;
            4'd12:   t = 16'sd2;
            4'd13:   t = 16'sd1;
            default: t = 16'sd0;
        endcase
        return t;
    endfunction

    // Rotate toward zero residual: negative Z adds the angle back.
    function automatic logic signed [15:0] step_angle(
        input logic [3:0] i,
        input logic       z_neg
    );
        logic signed [15:0] t;
        t = atan_lut(i);
        return z_neg ? t : -t;
    endfunction

    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        arctan_d = arctan_q;
        unique case (state_q)
            S_IDLE: begin
                iter_d   = 4'd0;
                arctan_d = 16'sd0;
                if (bus.start_i) begin
                    state_d  = S_ISSUE;
                    arctan_d = step_angle(4'd0, bus.z_sign_i);
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Z_sign here already reflects the previous step's update.
                if (iter_q < LAST) begin
                    state_d  = S_ISSUE;
                    iter_d   = iter_q + 4'd1;
                    arctan_d = step_angle(iter_q + 4'd1, bus.z_sign_i);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                iter_d   = 4'd0;
                arctan_d = 16'sd0;
            end
        endcase
    end

    // Flags are derived from the next state so every output is a flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            iter_q   <= 4'd0;
            arctan_q <= 16'sd0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            iter_q   <= iter_d;
            arctan_q <= arctan_d;
            enable_q <= (state_d == S_ISSUE);
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
        end
    end

    assign bus.enable_o = enable_q;
    assign bus.arctan_o = arctan_q;
    assign bus.iter_o   = iter_q;
    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
endmodule

// File: tb/tb_cordic_angle_seq.sv
// Self-checking bench for cordic_angle_seq (N_ITER=16 and N_ITER=1 instances).
// Expected steps are queued when Start/Z_sign are driven and popped on each Enable.
module tb_cordic_angle_seq;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    typedef struct {
        logic [3:0]         iter;
        logic signed [15:0] at;
    } exp_t;

    exp_t sb[$];

    int tbl[16] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64,
                    32, 16, 8, 4, 2, 1, 0, 0};

    cordic_angle_seq_if b16 ();
    cordic_angle_seq_if b1 ();

    cordic_angle_seq #(.N_ITER(16)) dut16 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b16.slave)
    );

    cordic_angle_seq #(.N_ITER(1)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit zsel(input int mode, input int i);
        return (mode == 0) ? 1'b1 : bit'(i % 2);
    endfunction

    task automatic push_exp(input int i, input bit z);
        exp_t e;
        e.iter = 4'(i);
        e.at   = z ? 16'(tbl[i]) : 16'(-tbl[i]);
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag, input logic [3:0] it,
                           input logic signed [15:0] at,
                           output logic signed [15:0] held);
        exp_t e;
        held = at;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'sd1, 32'sd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_iter"}, it, e.iter);
            check({tag, "_arctan"}, at, e.at);
            held = e.at;
        end
    endtask

    // mode 0: Z_sign held 1; mode 1: Z_sign = i%2 at each issue.
    // hold keeps Start high throughout; abort_at resets in WAIT of that iter.
    task automatic run_op(input int mode, input bit hold, input int abort_at);
        logic signed [15:0] held;
        b16.start_i  = 1'b1;
        b16.z_sign_i = zsel(mode, 0);
        push_exp(0, zsel(mode, 0));
        tick();
        if (!hold) b16.start_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("issue_enable", b16.enable_o, 1);
            check("issue_busy", b16.busy_o, 1);
            check("issue_done", b16.done_o, 0);
            pop_cmp("issue", b16.iter_o, b16.arctan_o, held);
            b16.z_sign_i = 1'($urandom_range(0, 1));
            tick();
            check("wait_enable", b16.enable_o, 0);
            check("wait_busy", b16.busy_o, 1);
            check("wait_done", b16.done_o, 0);
            check("wait_arctan_hold", b16.arctan_o, held);
            if (i == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("abort_enable", b16.enable_o, 0);
                check("abort_busy", b16.busy_o, 0);
                check("abort_done", b16.done_o, 0);
                check("abort_arctan", b16.arctan_o, 0);
                check("abort_iter", b16.iter_o, 0);
                sb.delete();
                tick();
                check("abort_no_done", b16.done_o, 0);
                check("abort_idle_enable", b16.enable_o, 0);
                return;
            end
            if (i < 15) begin
                b16.z_sign_i = zsel(mode, i + 1);
                push_exp(i + 1, zsel(mode, i + 1));
            end
            tick();
        end
        check("done_pulse", b16.done_o, 1);
        check("done_busy", b16.busy_o, 1);
        check("done_enable", b16.enable_o, 0);
        check("done_arctan_hold", b16.arctan_o, held);
        tick();
        check("idle_busy", b16.busy_o, 0);
        check("idle_done", b16.done_o, 0);
        check("idle_enable", b16.enable_o, 0);
        check("idle_arctan", b16.arctan_o, 0);
    endtask

    initial begin
        logic signed [15:0] held;
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        b16.start_i  = 1'b0;
        b16.z_sign_i = 1'b0;
        b1.start_i   = 1'b0;
        b1.z_sign_i  = 1'b0;
        tick();
        tick();
        check("rst_enable", b16.enable_o, 0);
        check("rst_busy", b16.busy_o, 0);
        check("rst_done", b16.done_o, 0);
        check("rst_arctan", b16.arctan_o, 0);
        check("rst_iter", b16.iter_o, 0);
        check("rst1_enable", b1.enable_o, 0);
        check("rst1_busy", b1.busy_o, 0);
        rst = 1'b0;
        tick();

        run_op(0, 1'b0, -1);
        run_op(1, 1'b0, -1);

        run_op(0, 1'b1, -1);
        run_op(1, 1'b1, -1);
        run_op(0, 1'b0, -1);

        run_op(0, 1'b0, 5);
        run_op(1, 1'b0, -1);

        rst         = 1'b1;
        b16.start_i = 1'b1;
        tick();
        check("rs_enable", b16.enable_o, 0);
        check("rs_busy", b16.busy_o, 0);
        rst         = 1'b0;
        b16.start_i = 1'b0;
        tick();
        check("rs_after_enable", b16.enable_o, 0);
        check("rs_after_busy", b16.busy_o, 0);

        b1.start_i  = 1'b1;
        b1.z_sign_i = 1'b0;
        push_exp(0, 1'b0);
        tick();
        b1.start_i = 1'b0;
        check("n1_enable", b1.enable_o, 1);
        pop_cmp("n1", b1.iter_o, b1.arctan_o, held);
        tick();
        check("n1_wait_enable", b1.enable_o, 0);
        check("n1_wait_done", b1.done_o, 0);
        tick();
        check("n1_done", b1.done_o, 1);
        check("n1_done_arctan", b1.arctan_o, held);
        tick();
        check("n1_idle_done", b1.done_o, 0);
        check("n1_idle_busy", b1.busy_o, 0);
        check("n1_idle_enable", b1.enable_o, 0);

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
